// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage MIPS32 pipeline.
// Resolves data hazards, sequences the multi-cycle divider, and squashes on MEM exceptions.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jumpregD,
    input  logic       div_startE,
    input  logic       excM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       div_busy,
    output logic       div_done
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lwstall, brstall, divstall;

    // $0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        if (regwriteM && hit(writeregM, rsE))      forwardAE = 2'b10;
        else if (regwriteW && hit(writeregW, rsE)) forwardAE = 2'b01;
        forwardBE = 2'b00;
        if (regwriteM && hit(writeregM, rtE))      forwardBE = 2'b10;
        else if (regwriteW && hit(writeregW, rtE)) forwardBE = 2'b01;
    end

    assign forwardAD = regwriteM && hit(writeregM, rsD);
    assign forwardBD = regwriteM && hit(writeregM, rtD);

    assign lwstall = memtoregE && regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD));
    assign brstall = (branchD || jumpregD) &&
                     ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                      (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        divstall = 1'b0;
        div_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (div_startE) begin
                    divstall = 1'b1;
                    state_d  = StBusy;
                    cnt_d    = CNT_W'(DIV_CYCLES - 1);
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    divstall = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    div_done = !excM;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // An exception abandons any divide, including one requested this cycle.
        if (excM) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    assign div_busy = (state_q == StBusy);

    always_comb begin
        stallF = lwstall || brstall || divstall;
        stallD = lwstall || brstall || divstall;
        stallE = divstall;
        flushD = 1'b0;
        flushE = (lwstall || brstall) && !divstall;
        flushM = divstall;
        flushW = 1'b0;
        if (excM) begin
            stallF = 1'b0;
            stallD = 1'b0;
            stallE = 1'b0;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage MIPS32 pipeline.
- It produces the flush and stall inputs consumed by every synchronous-clear pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- It selects forwarding paths and sequences the multi-cycle divider stall with an internal FSM.
- Exceptions reported from MEM squash all younger stages.

Parameters:
- DIV_CYCLES, 32, total EX stall cycles per divide; legal minimum 2.
- CNT_W, 6, divide counter width; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rsD, rtD  in  5 each  source registers in ID.
- rsE, rtE  in  5 each  source registers in EX.
- writeregE, writeregM, writeregW  in  5 each  destination registers.
- regwriteE, regwriteM, regwriteW  in  1 each  destination-write enables.
- memtoregE, memtoregM  in  1 each  load in EX / MEM.
- branchD, jumpregD  in  1 each  branch / jr in ID (operands compared in ID).
- div_startE  in  1  divide in EX; level, held while the divide sits in EX.
- excM  in  1  exception taken at MEM.
- stallF, stallD, stallE  out  1 each  hold PC, IF/ID, ID/EX.
- flushD, flushE, flushM, flushW  out  1 each  clear IF/ID, ID/EX, EX/MEM, MEM/WB.
- forwardAD, forwardBD  out  1 each  ID comparator bypass from MEM.
- forwardAE, forwardBE  out  2 each  EX ALU operand select.
- div_busy  out  1  divider FSM in BUSY.
- div_done  out  1  one-cycle pulse: quotient valid in EX.

Behaviour:
- Register 0 never matches in any hazard or forward comparison.
- Forwarding (combinational):
  - forwardAE = 2'b10 if regwriteM and writeregM==rsE; else 2'b01 if regwriteW and writeregW==rsE; else 2'b00. MEM has priority.
  - forwardBE is identical, using rtE.
  - forwardAD = regwriteM and writeregM==rsD. forwardBD is identical, using rtD.
- lwstall = memtoregE and regwriteE and writeregE in {rsD, rtD}.
- brstall = (branchD or jumpregD) and ((regwriteE and writeregE in {rsD, rtD}) or (memtoregM and writeregM in {rsD, rtD})).
- Divide FSM, states IDLE and BUSY, with counter cnt[CNT_W-1:0]:
  - IDLE with div_startE=1 and excM=0: go to BUSY, cnt <= DIV_CYCLES-1.
  - BUSY with cnt!=0: cnt <= cnt-1.
  - BUSY with cnt==0: div_done=1 (combinational), next state IDLE. div_startE is ignored while in BUSY.
  - divstall = (IDLE and div_startE) or (BUSY and cnt!=0). This gives exactly DIV_CYCLES consecutive stall cycles, followed by the div_done cycle.
  - div_busy = (state==BUSY).
- Output equations when excM=0:
  - stallF = stallD = lwstall or brstall or divstall.
  - stallE = divstall.
  - flushE = (lwstall or brstall) and not divstall.
  - flushM = divstall (bubble into MEM while EX is held).
  - flushD = flushW = 0.
- excM=1 overrides everything:
  - flushD = flushE = flushM = flushW = 1; all stalls = 0.
  - FSM is forced to IDLE with cnt <= 0 at the next edge; div_done = 0 in that cycle.
  - A div_startE seen in the same cycle does not start a divide.
- Reset:
  - Asynchronous; FSM goes to IDLE and cnt to 0 immediately.
  - div_busy = div_done = 0 while reset is high.
  - Other outputs remain combinational functions of their inputs.
  - Reset mid-divide abandons it with no div_done pulse.
- Back-to-back divides: a new div_startE is accepted on the first IDLE cycle after div_done.

Test Plan:
- Load-use: lw $8 in EX (memtoregE=1, regwriteE=1, writeregE=8), rsD=8 -> stallF=stallD=1, flushE=1, stallE=0, for 1 cycle.
- Branch hazard: branchD=1, rtD=9, regwriteE=1, writeregE=9 -> stallD=1, flushE=1. Next cycle memtoregM=1, writeregM=9 -> stall again. Then with writeregM=9, regwriteM=1 and no load -> forwardBD=1, no stall.
- Forward priority: rsE=5, writeregM=writeregW=5, both regwrites high -> forwardAE=2'b10. With regwriteM=0 -> 2'b01. With rsE=0 -> 2'b00.
- Divide with DIV_CYCLES=4: div_startE held high -> stallE=1 and flushM=1 for exactly 4 cycles, div_busy high 4 cycles, div_done pulse in the 5th cycle, stallE=0 that cycle.
- Exception mid-divide: excM=1 in the 2nd BUSY cycle -> all four flushes 1, stalls 0, next cycle div_busy=0, no div_done.
- Reset mid-divide: reset asserted during BUSY -> div_busy drops without waiting for clk. After release with div_startE=1, a full DIV_CYCLES stall restarts.
